// File: rtl/nn_isa_pkg.sv
// nn_isa_pkg: shared ISA constants and the fetch-stage state encoding.
package nn_isa_pkg;

    localparam int INSTR_W = 16;
    localparam int OPC_W   = 4;

    localparam logic [OPC_W-1:0] OPC_NOP  = 4'h0;
    localparam logic [OPC_W-1:0] OPC_ADD  = 4'h1;
    localparam logic [OPC_W-1:0] OPC_MUL  = 4'h2;
    localparam logic [OPC_W-1:0] OPC_SLT  = 4'h3;
    localparam logic [OPC_W-1:0] OPC_MAC  = 4'h4;
    localparam logic [OPC_W-1:0] OPC_HALT = 4'hB;
    localparam logic [OPC_W-1:0] OPC_LD   = 4'hE;
    localparam logic [OPC_W-1:0] OPC_ST   = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        HALTED
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: output register plus one-entry skid, valid/ready on both sides.
module fetch_skid_buf #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         in_ready_o,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o,
    input  logic         out_ready_i,
    output logic         empty_o
);

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         in_fire, load_out;

    assign in_ready_o  = !skid_valid_q;
    assign in_fire     = in_valid_i && in_ready_o;
    // Output slot refills when empty or draining; the skid always has priority.
    assign load_out    = !out_valid_q || out_ready_i;

    always_comb begin
        out_valid_d  = load_out ? (skid_valid_q || in_fire) : 1'b1;
        out_data_d   = !load_out ? out_data_q : (skid_valid_q ? skid_data_q : (in_fire ? in_data_i : out_data_q));
        skid_valid_d = load_out ? 1'b0 : (skid_valid_q || in_fire);
        skid_data_d  = (!load_out && in_fire) ? in_data_i : skid_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign empty_o     = !out_valid_q && !skid_valid_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC + imem req/ack fetch FSM feeding the decoder through a skid buffer.
module instr_fetch_unit
    import nn_isa_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int INSTR_W    = nn_isa_pkg::INSTR_W,
    parameter int START_ADDR = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_ack_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    input  logic               stall_i,
    output logic               if_valid_o,
    output logic [INSTR_W-1:0] if_instr_o,
    output logic [OPC_W-1:0]   if_opcode_o,
    output logic [ADDR_W-1:0]  if_pc_o,
    output logic               halted_o
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              req, push, buf_ready, buf_empty, is_halt;

    assign is_halt = imem_rdata_i[INSTR_W-1 -: OPC_W] == OPC_HALT;

    // req only falls when the skid fills, which needs an ack, so it is sticky.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req     = 1'b0;
        push    = 1'b0;
        unique case (state_q)
            IDLE:  state_d = start_i ? FETCH : IDLE;
            FETCH: begin
                req = buf_ready;
                if (req && imem_ack_i) begin
                    state_d = is_halt ? DRAIN : FETCH;
                    push    = !is_halt;
                    pc_d    = is_halt ? pc_q : pc_q + 1'b1;
                end
            end
            DRAIN: state_d = buf_empty ? HALTED : DRAIN;
            default: state_d = HALTED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= ADDR_W'(START_ADDR);
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_skid_buf #(.W(INSTR_W + ADDR_W)) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (push),
        .in_data_i   ({imem_rdata_i, pc_q}),
        .in_ready_o  (buf_ready),
        .out_valid_o (if_valid_o),
        .out_data_o  ({if_instr_o, if_pc_o}),
        .out_ready_i (!stall_i),
        .empty_o     (buf_empty)
    );

    assign imem_req_o  = req;
    assign imem_addr_o = req ? pc_q : '0;
    assign if_opcode_o = if_instr_o[INSTR_W-1 -: OPC_W];
    assign halted_o    = state_q == HALTED;

endmodule
